// File: rtl/io_thresh_fifo_pkg.sv
// rtl/io_thresh_fifo_pkg.sv - default geometry for io_thresh_fifo, taken from perips_cfg.vh.
`include "perips_cfg.vh"

package io_thresh_fifo_pkg;
  localparam int DEF_DATA_WIDTH   = `PERIPS_FIFO_WIDTH;
  localparam int DEF_BUFFER_DEPTH = `PERIPS_FIFO_DEPTH;
endpackage

// File: rtl/io_fifo_wrap_ptr.sv
// rtl/io_fifo_wrap_ptr.sv - modulo-DEPTH pointer with synchronous clear; clear beats increment.
module io_fifo_wrap_ptr #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [PTR_W-1:0] ptr
);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [PTR_W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
endmodule

// File: rtl/perips_cfg.vh
// rtl/perips_cfg.vh - shared peripheral FIFO constants; IO_FIFO_HWM_EN stays off unless defined by the build.
`ifndef PERIPS_CFG_VH
`define PERIPS_CFG_VH

`define PERIPS_FIFO_WIDTH 32
`define PERIPS_FIFO_DEPTH 8

`endif

// File: rtl/io_thresh_fifo.sv
// rtl/io_thresh_fifo.sv - first-word-fall-through FIFO with almost-full/empty thresholds.
// Optional high-water mark register enabled by IO_FIFO_HWM_EN.
`include "perips_cfg.vh"

module io_thresh_fifo
  import io_thresh_fifo_pkg::*;
#(
  parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
  parameter int BUFFER_DEPTH     = DEF_BUFFER_DEPTH,
  parameter int LOG_BUFFER_DEPTH = $clog2(BUFFER_DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr_i,
  input  logic                        valid_i,
  input  logic [DATA_WIDTH-1:0]       data_i,
  output logic                        ready_o,
  output logic                        valid_o,
  output logic [DATA_WIDTH-1:0]       data_o,
  input  logic                        ready_i,
  output logic [LOG_BUFFER_DEPTH:0]   elements_o,
  output logic [LOG_BUFFER_DEPTH:0]   free_o,
  input  logic [LOG_BUFFER_DEPTH:0]   af_thr_i,
  input  logic [LOG_BUFFER_DEPTH:0]   ae_thr_i,
  output logic                        almost_full_o,
  output logic                        almost_empty_o,
  input  logic                        hwm_clr_i,
  output logic [LOG_BUFFER_DEPTH:0]   hwm_o
);
  localparam int CW = LOG_BUFFER_DEPTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUFFER_DEPTH);

  logic [DATA_WIDTH-1:0]       mem_q [BUFFER_DEPTH];
  logic [LOG_BUFFER_DEPTH-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]               elements_q, elements_d;
  logic                        push, pop;

  assign ready_o = (elements_q != DEPTH_C);
  assign valid_o = (elements_q != '0);
  assign push    = valid_i & ready_o;
  assign pop     = valid_o & ready_i;

  io_fifo_wrap_ptr #(.DEPTH(BUFFER_DEPTH), .PTR_W(LOG_BUFFER_DEPTH)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (push),
    .clr (clr_i),
    .ptr (wr_ptr)
  );

  io_fifo_wrap_ptr #(.DEPTH(BUFFER_DEPTH), .PTR_W(LOG_BUFFER_DEPTH)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (pop),
    .clr (clr_i),
    .ptr (rd_ptr)
  );

  always_comb begin
    elements_d = elements_q;
    if (clr_i) begin
      elements_d = '0;
    end else if (push && !pop) begin
      elements_d = elements_q + CW'(1);
    end else if (pop && !push) begin
      elements_d = elements_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) elements_q <= '0;
    else     elements_q <= elements_d;
  end

  // Storage is deliberately unreset; a flushed push must not land in the array.
  always_ff @(posedge clk) begin
    if (push && !clr_i) mem_q[wr_ptr] <= data_i;
  end

  assign data_o         = mem_q[rd_ptr];
  assign elements_o     = elements_q;
  assign free_o         = DEPTH_C - elements_q;
  assign almost_full_o  = (elements_q >= af_thr_i);
  assign almost_empty_o = (elements_q <= ae_thr_i);

`ifdef IO_FIFO_HWM_EN
  logic [CW-1:0] hwm_q, hwm_d;

  always_comb begin
    hwm_d = hwm_q;
    if (clr_i || hwm_clr_i) begin
      hwm_d = '0;
    end else if (elements_d > hwm_q) begin
      hwm_d = elements_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hwm_q <= '0;
    else     hwm_q <= hwm_d;
  end

  assign hwm_o = hwm_q;
`else
  logic hwm_clr_unused;
  assign hwm_clr_unused = hwm_clr_i;
  assign hwm_o          = '0;
`endif
endmodule

// File: tb/tb_io_thresh_fifo.sv
// tb/tb_io_thresh_fifo.sv - directed self-checking bench for io_thresh_fifo (depth 8 and depth 5).
module tb_io_thresh_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic        clr8, val8, rdy8_i, hclr8;
  logic [31:0] din8, dout8;
  logic        rdy8_o, val8_o, af8, ae8;
  logic [3:0]  el8, fr8, hwm8;
  logic [3:0]  af_thr, ae_thr;

  logic        clr5, val5, rdy5_i, hclr5;
  logic [31:0] din5, dout5;
  logic        rdy5_o, val5_o, af5, ae5;
  logic [3:0]  el5, fr5, hwm5;

`ifdef IO_FIFO_HWM_EN
  localparam bit HWM = 1'b1;
`else
  localparam bit HWM = 1'b0;
`endif

  io_thresh_fifo #(.DATA_WIDTH(32), .BUFFER_DEPTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .clr_i(clr8), .valid_i(val8), .data_i(din8),
    .ready_o(rdy8_o), .valid_o(val8_o), .data_o(dout8), .ready_i(rdy8_i),
    .elements_o(el8), .free_o(fr8), .af_thr_i(af_thr), .ae_thr_i(ae_thr),
    .almost_full_o(af8), .almost_empty_o(ae8), .hwm_clr_i(hclr8), .hwm_o(hwm8)
  );

  io_thresh_fifo #(.DATA_WIDTH(32), .BUFFER_DEPTH(5)) u_dut5 (
    .clk(clk), .rst(rst), .clr_i(clr5), .valid_i(val5), .data_i(din5),
    .ready_o(rdy5_o), .valid_o(val5_o), .data_o(dout5), .ready_i(rdy5_i),
    .elements_o(el5), .free_o(fr5), .af_thr_i(af_thr), .ae_thr_i(ae_thr),
    .almost_full_o(af5), .almost_empty_o(ae5), .hwm_clr_i(hclr5), .hwm_o(hwm5)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] q5[$];
    logic [31:0] exp_word;
    logic [31:0] pushed5;
    clr8 = 0; val8 = 0; rdy8_i = 0; hclr8 = 0; din8 = '0;
    clr5 = 0; val5 = 0; rdy5_i = 0; hclr5 = 0; din5 = '0;
    af_thr = 4'd6; ae_thr = 4'd2;
    tick; tick;
    rst = 1'b0;
    tick;

    chk("rst_ready", {31'b0, rdy8_o}, 32'd1);
    chk("rst_valid", {31'b0, val8_o}, 32'd0);
    chk("rst_elements", {28'b0, el8}, 32'd0);
    chk("rst_free", {28'b0, fr8}, 32'd8);
    chk("rst_hwm", {28'b0, hwm8}, 32'd0);
    chk("ae_count0", {31'b0, ae8}, 32'd1);
    chk("af_count0", {31'b0, af8}, 32'd0);

    // Fill 0->8 with A0..A7; thresholds af=6, ae=2
    for (int i = 0; i < 8; i++) begin
      val8 = 1'b1; din8 = 32'hA0 + i;
      tick;
      chk("fill_elements", {28'b0, el8}, i + 1);
      chk("fill_ae", {31'b0, ae8}, ((i + 1) <= 2) ? 32'd1 : 32'd0);
      chk("fill_af", {31'b0, af8}, ((i + 1) >= 6) ? 32'd1 : 32'd0);
    end
    chk("full_ready", {31'b0, rdy8_o}, 32'd0);
    chk("full_free", {28'b0, fr8}, 32'd0);

    din8 = 32'hFF;
    tick;
    chk("ninth_elements", {28'b0, el8}, 32'd8);
    chk("ninth_data", dout8, 32'hA0);
    chk("ninth_valid", {31'b0, val8_o}, 32'd1);
    val8 = 1'b0;

    rdy8_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_data", dout8, 32'hA0 + i);
      tick;
    end
    rdy8_i = 1'b0;
    chk("drain_valid", {31'b0, val8_o}, 32'd0);
    chk("drain_elements", {28'b0, el8}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      val8 = 1'b1; din8 = 32'hB0 + i;
      tick;
    end
    // Full with push and pop together: write refused, pop proceeds
    din8 = 32'hEE; rdy8_i = 1'b1;
    tick;
    chk("fullpop_elements", {28'b0, el8}, 32'd7);
    chk("fullpop_ready", {31'b0, rdy8_o}, 32'd1);
    chk("fullpop_data", dout8, 32'hB1);
    val8 = 1'b0;
    for (int i = 0; i < 4; i++) tick;
    rdy8_i = 1'b0;
    chk("pre_clr_elements", {28'b0, el8}, 32'd3);
    chk("pre_clr_data", dout8, 32'hB5);

    clr8 = 1'b1; val8 = 1'b1; rdy8_i = 1'b1; din8 = 32'hCC;
    tick;
    clr8 = 1'b0; val8 = 1'b0; rdy8_i = 1'b0;
    chk("clr_elements", {28'b0, el8}, 32'd0);
    chk("clr_valid", {31'b0, val8_o}, 32'd0);
    chk("clr_free", {28'b0, fr8}, 32'd8);
    chk("clr_hwm", {28'b0, hwm8}, 32'd0);

    for (int i = 0; i < 7; i++) begin
      val8 = 1'b1; din8 = 32'hD0 + i;
      tick;
    end
    val8 = 1'b0; rdy8_i = 1'b1;
    for (int i = 0; i < 6; i++) tick;
    rdy8_i = 1'b0;
    chk("hwm_el_after_drain", {28'b0, el8}, 32'd1);
    chk("hwm_peak", {28'b0, hwm8}, HWM ? 32'd7 : 32'd0);
    chk("hwm_data", dout8, 32'hD6);
    hclr8 = 1'b1;
    tick;
    hclr8 = 1'b0;
    chk("hwm_cleared", {28'b0, hwm8}, 32'd0);
    tick;
    chk("hwm_after_clr", {28'b0, hwm8}, HWM ? 32'd1 : 32'd0);

    // Depth 5: prime 3, then push+pop together, then drain; pointers wrap 4->0
    pushed5 = 0;
    for (int i = 0; i < 3; i++) begin
      val5 = 1'b1; din5 = 32'hC0 + pushed5; q5.push_back(din5); pushed5++;
      tick;
    end
    chk("d5_prime_elements", {28'b0, el5}, 32'd3);
    rdy5_i = 1'b1;
    for (int i = 3; i < 12; i++) begin
      val5 = 1'b1; din5 = 32'hC0 + pushed5; q5.push_back(din5); pushed5++;
      exp_word = q5.pop_front();
      chk("d5_stream_data", dout5, exp_word);
      tick;
      chk("d5_stream_elements", {28'b0, el5}, 32'd3);
    end
    val5 = 1'b0;
    while (q5.size() > 0) begin
      exp_word = q5.pop_front();
      chk("d5_drain_data", dout5, exp_word);
      tick;
    end
    rdy5_i = 1'b0;
    chk("d5_empty_valid", {31'b0, val5_o}, 32'd0);
    chk("d5_empty_free", {28'b0, fr5}, 32'd5);

    // Empty with ready_i high: no change
    rdy5_i = 1'b1;
    tick;
    rdy5_i = 1'b0;
    chk("d5_empty_pop_elements", {28'b0, el5}, 32'd0);

    // Asynchronous reset mid-cycle abandons a pending push
    val8 = 1'b1; din8 = 32'h11;
    tick;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_elements", {28'b0, el8}, 32'd0);
    chk("async_rst_ready", {31'b0, rdy8_o}, 32'd1);
    val8 = 1'b0;
    tick;
    rst = 1'b0;
    tick;
    chk("post_rst_valid", {31'b0, val8_o}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/io_thresh_fifo.md
IO_THRESH_FIFO -- requirements
Module: io_thresh_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, payload width in bits.
REQ-002 SHALL have parameter BUFFER_DEPTH, default 8, entry count; any integer >= 2, power of two not required.
REQ-003 SHALL have parameter LOG_BUFFER_DEPTH, default $clog2(BUFFER_DEPTH), pointer width.
REQ-004 SHALL have ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr_i  in  1  synchronous flush.
- valid_i  in  1  write valid.
- data_i  in  DATA_WIDTH  write data.
- ready_o  out  1  write ready.
- valid_o  out  1  read valid.
- data_o  out  DATA_WIDTH  read data, head entry.
- ready_i  in  1  read ready.
- elements_o  out  LOG_BUFFER_DEPTH+1  current occupancy.
- free_o  out  LOG_BUFFER_DEPTH+1  BUFFER_DEPTH - occupancy.
- af_thr_i  in  LOG_BUFFER_DEPTH+1  almost-full threshold.
- ae_thr_i  in  LOG_BUFFER_DEPTH+1  almost-empty threshold.
- almost_full_o  out  1  occupancy >= af_thr_i.
- almost_empty_o  out  1  occupancy <= ae_thr_i.
- hwm_clr_i  in  1  high-water clear (IO_FIFO_HWM_EN only).
- hwm_o  out  LOG_BUFFER_DEPTH+1  peak occupancy (IO_FIFO_HWM_EN only).

Function
REQ-005 SHALL define push = valid_i & ready_o and pop = valid_o & ready_i.
REQ-006 SHALL drive ready_o = (elements != BUFFER_DEPTH) and valid_o = (elements != 0), both from registered occupancy.
REQ-007 SHALL be first-word-fall-through: data_o = buffer[rd_ptr] combinationally; a pushed word is visible on data_o the cycle after the push edge.
REQ-008 SHALL on push write data_i to buffer[wr_ptr] and advance wr_ptr; on pop advance rd_ptr.
REQ-009 SHALL wrap each pointer from BUFFER_DEPTH-1 to 0; no other wrap.
REQ-010 SHALL update elements: +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-011 SHALL, when full, refuse a write even if a pop occurs the same cycle (ready_o stays low); occupancy goes to BUFFER_DEPTH-1.
REQ-012 SHALL, when empty, ignore ready_i; no pointer or count change.
REQ-013 SHALL compute almost_full_o, almost_empty_o, free_o combinationally from registered elements and live threshold inputs; thresholds are unsigned and full width.
REQ-014 SHALL on clr_i zero both pointers and elements at the next edge, overriding a simultaneous push or pop; the data array is not cleared.
REQ-015 SHALL never change data_o, valid_o or elements when valid_i is high while full.

Reset
REQ-016 SHALL asynchronously clear wr_ptr, rd_ptr, elements and hwm on rst assertion. Post-reset outputs: ready_o=1, valid_o=0, elements_o=0, free_o=BUFFER_DEPTH, hwm_o=0.
REQ-017 SHALL leave the data array unreset; data_o is undefined while valid_o=0.
REQ-018 SHALL abandon any in-flight push or pop if rst asserts mid-cycle; no partial state survives.

Configuration
REQ-019 SHALL gate the high-water feature with macro IO_FIFO_HWM_EN.
REQ-020 SHALL, with IO_FIFO_HWM_EN defined, register hwm = max(hwm, next elements) every cycle, and zero it on rst, clr_i or hwm_clr_i (clear wins over update).
REQ-021 SHALL, without IO_FIFO_HWM_EN, omit the hwm register, tie hwm_o to 0 and ignore hwm_clr_i; the port list is unchanged.

Structure
REQ-022 SHALL place the IO_FIFO_HWM_EN default and shared FIFO depth/width constants in perips_cfg.vh.
REQ-023 SHALL implement each pointer as one sub-module, io_fifo_wrap_ptr: parameter DEPTH, inputs inc and clr, output ptr, wrap at DEPTH-1. It is instantiated twice.

Verification
REQ-024 SHALL cover, with DEPTH=8 and WIDTH=32: reset, then push 0xA0..0xA7 without popping -> ready_o=0 after the 8th push, elements_o=8, free_o=0; 9th valid_i is not accepted.
REQ-025 SHALL cover: pop all 8 -> data_o sequence 0xA0..0xA7, then valid_o=0, elements_o=0.
REQ-026 SHALL cover, with DEPTH=5: 12 pushes interleaved with pops -> wrap from 4 to 0 and in-order data with no loss.
REQ-027 SHALL cover, with af_thr_i=6 and ae_thr_i=2: fill 0->8 -> almost_empty_o high for counts 0..2, almost_full_o high for counts 6..8.
REQ-028 SHALL cover: occupancy 3 with clr_i, valid_i and ready_i all high in one cycle -> elements_o=0, valid_o=0 the next cycle.
REQ-029 SHALL cover, with IO_FIFO_HWM_EN: fill to 7, drain to 1 -> hwm_o=7; pulse hwm_clr_i -> hwm_o=1. Without the macro, hwm_o stays 0 throughout.
